// File: rtl/dkong3_pkg.sv
// Shared types and constants for the Donkey Kong 3 tile VRAM arbiter.
package dkong3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ISS  = 2'd1,
    DAT  = 2'd2,
    END  = 2'd3
  } cpu_st_t;

  localparam logic [9:0] FETCH_BEG = 10'd760;
  localparam logic [9:0] FETCH_END = 10'd504;
  localparam logic [2:0] VID_SLOT  = 3'd0;
  localparam logic [9:0] H_MOD     = 10'd768;

  // The fetch window wraps through 767->0, hence the OR of the two bounds.
  function automatic logic in_window(input logic [9:0] h, input logic vbl_n);
    return vbl_n & ((h >= FETCH_BEG) | (h < FETCH_END));
  endfunction

endpackage

// File: rtl/dkong3_vram_slot_dec.sv
// Slot decode: fetch window, video issue strobe, CPU block and the delayed video return.
// Macro DKONG3_VRAM_SLOT_SHARE_EN narrows the CPU block to the video slot H count.
module dkong3_vram_slot_dec
  import dkong3_pkg::*;
(
  input  logic       I_CLK,
  input  logic       I_RST_n,
  input  logic       I_PIX_CE,
  input  logic [9:0] I_H_CNT,
  input  logic       I_V_BLANKn,
  output logic       vid_iss_s,
  output logic       cpu_blk_s,
  output logic       vid_ret_r
);

  logic inwin_s;
  logic slot_s;
  logic vid_p1_r;
  logic vid_p2_r;

  assign inwin_s   = in_window(I_H_CNT, I_V_BLANKn);
  assign slot_s    = (I_H_CNT[2:0] == VID_SLOT);
  assign vid_iss_s = I_PIX_CE & inwin_s & slot_s;

`ifdef DKONG3_VRAM_SLOT_SHARE_EN
  assign cpu_blk_s = inwin_s & slot_s;
`else
  assign cpu_blk_s = inwin_s;
`endif

  // Two-stage delay matching the registered port plus the RAM's read latency.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      vid_p1_r <= 1'b0;
      vid_p2_r <= 1'b0;
    end else begin
      vid_p1_r <= vid_iss_s;
      vid_p2_r <= vid_p1_r;
    end
  end

  assign vid_ret_r = vid_p2_r;

endmodule

// File: rtl/dkong3_vram_arb.sv
// Tile VRAM time-slot arbiter: video fetch owns its reserved slot, the Z80 gets the rest.
// Macro DKONG3_VRAM_SLOT_SHARE_EN lets the CPU use non-slot H counts inside the window.
module dkong3_vram_arb
  import dkong3_pkg::*;
(
  input  logic       I_CLK,
  input  logic       I_RST_n,
  input  logic       I_PIX_CE,
  input  logic [9:0] I_H_CNT,
  input  logic       I_V_BLANKn,
  input  logic       I_CPU_REQ,
  input  logic       I_CPU_WE,
  input  logic [9:0] I_CPU_ADDR,
  input  logic [7:0] I_CPU_DIN,
  output logic [7:0] O_CPU_DOUT,
  output logic       O_CPU_ACK,
  output logic       O_CPU_WAITn,
  input  logic [9:0] I_VID_ADDR,
  output logic [7:0] O_VID_DOUT,
  output logic       O_VID_STB,
  output logic [9:0] O_RAM_ADDR,
  output logic       O_RAM_WE,
  output logic [7:0] O_RAM_DIN,
  input  logic [7:0] I_RAM_DOUT
);

  cpu_st_t st_r;
  cpu_st_t st_nx_s;
  logic    vid_iss_s;
  logic    cpu_blk_s;
  logic    vid_ret_r;
  logic    cpu_iss_s;
  logic    cpu_dat_s;
  logic    cpu_we_r;

  dkong3_vram_slot_dec u_slot_dec (
    .I_CLK      (I_CLK),
    .I_RST_n    (I_RST_n),
    .I_PIX_CE   (I_PIX_CE),
    .I_H_CNT    (I_H_CNT),
    .I_V_BLANKn (I_V_BLANKn),
    .vid_iss_s  (vid_iss_s),
    .cpu_blk_s  (cpu_blk_s),
    .vid_ret_r  (vid_ret_r)
  );

  // CPU access state register.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      st_r <= IDLE;
    end else begin
      st_r <= st_nx_s;
    end
  end

  // CPU access next state; END waits for REQ to drop so a held request is served once.
  always_comb begin
    st_nx_s = st_r;
    case (st_r)
      IDLE: begin
        if (I_CPU_REQ && !cpu_blk_s) st_nx_s = ISS;
        else                         st_nx_s = IDLE;
      end
      ISS: st_nx_s = DAT;
      DAT: st_nx_s = END;
      END: begin
        if (!I_CPU_REQ) st_nx_s = IDLE;
        else            st_nx_s = END;
      end
      default: st_nx_s = IDLE;
    endcase
  end

  // CPU access output decode.
  always_comb begin
    cpu_iss_s = 1'b0;
    cpu_dat_s = 1'b0;
    case (st_r)
      IDLE:    cpu_iss_s = I_CPU_REQ & ~cpu_blk_s;
      ISS:     cpu_dat_s = 1'b0;
      DAT:     cpu_dat_s = 1'b1;
      END:     cpu_dat_s = 1'b0;
      default: cpu_dat_s = 1'b0;
    endcase
  end

  // RAM port; the block guarantees video and CPU never load on the same edge.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      O_RAM_ADDR <= 10'd0;
      O_RAM_WE   <= 1'b0;
      O_RAM_DIN  <= 8'd0;
      cpu_we_r   <= 1'b0;
    end else if (vid_iss_s) begin
      O_RAM_ADDR <= I_VID_ADDR;
      O_RAM_WE   <= 1'b0;
    end else if (cpu_iss_s) begin
      O_RAM_ADDR <= I_CPU_ADDR;
      O_RAM_WE   <= I_CPU_WE;
      O_RAM_DIN  <= I_CPU_DIN;
      cpu_we_r   <= I_CPU_WE;
    end else begin
      O_RAM_WE   <= 1'b0;
    end
  end

  // CPU completion: read data is captured only for reads and held until the next read.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      O_CPU_ACK  <= 1'b0;
      O_CPU_DOUT <= 8'd0;
    end else begin
      O_CPU_ACK <= cpu_dat_s;
      if (cpu_dat_s && !cpu_we_r) O_CPU_DOUT <= I_RAM_DOUT;
    end
  end

  // Video return capture.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      O_VID_DOUT <= 8'd0;
      O_VID_STB  <= 1'b0;
    end else begin
      O_VID_STB <= vid_ret_r;
      if (vid_ret_r) O_VID_DOUT <= I_RAM_DOUT;
    end
  end

  // Combinational so WAIT asserts in the same cycle the Z80 raises its request.
  assign O_CPU_WAITn = ~(I_CPU_REQ & (st_r != END) & ~O_CPU_ACK);

endmodule

// File: tb/tb_dkong3_vram_arb.sv
// Scoreboard bench for dkong3_vram_arb: random CPU traffic against a slot-rule model plus directed corners.
module tb_dkong3_vram_arb;
  import dkong3_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic [9:0] h = 10'd0;
  logic       vbl_n = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [9:0] cpu_addr = 10'd0;
  logic [7:0] cpu_din = 8'd0;
  logic [9:0] vid_addr = 10'd0;
  logic [7:0] cpu_dout, vid_dout, ram_din;
  logic [7:0] ram_dout = 8'd0;
  logic       cpu_ack, cpu_waitn, vid_stb, ram_we;
  logic [9:0] ram_addr;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int last_iss_h = -1;

  logic [7:0] ram_mem [1024];
  bit         ram_vld [1024];
  logic [7:0] ref_mem [1024];

  typedef struct { int due; logic [7:0] data; } vexp_t;
  typedef struct { logic we; logic [7:0] data; } cexp_t;
  vexp_t vq[$];
  cexp_t cq[$];
  logic [7:0] last_rd = 8'd0;

  dkong3_vram_arb dut (
    .I_CLK(clk), .I_RST_n(rst_n), .I_PIX_CE(pix_ce), .I_H_CNT(h), .I_V_BLANKn(vbl_n),
    .I_CPU_REQ(cpu_req), .I_CPU_WE(cpu_we), .I_CPU_ADDR(cpu_addr), .I_CPU_DIN(cpu_din),
    .O_CPU_DOUT(cpu_dout), .O_CPU_ACK(cpu_ack), .O_CPU_WAITn(cpu_waitn),
    .I_VID_ADDR(vid_addr), .O_VID_DOUT(vid_dout), .O_VID_STB(vid_stb),
    .O_RAM_ADDR(ram_addr), .O_RAM_WE(ram_we), .O_RAM_DIN(ram_din), .I_RAM_DOUT(ram_dout)
  );

  always #20 clk = ~clk;

  function automatic logic [7:0] pat(input logic [9:0] a);
    return a[7:0] ^ {a[9:8], a[9:8], a[9:8], a[9:8]} ^ 8'h3C;
  endfunction

  // Synchronous single-port VRAM, read-before-write, one-cycle latency.
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
      ram_vld[ram_addr] <= 1'b1;
    end
    ram_dout <= ram_vld[ram_addr] ? ram_mem[ram_addr] : pat(ram_addr);
  end

  function automatic bit model_inwin(input int hv, input bit vb);
    return vb && (hv >= 760 || hv < 504);
  endfunction

  function automatic bit model_blocked();
`ifdef DKONG3_VRAM_SLOT_SHARE_EN
    return model_inwin(int'(h), vbl_n) && (int'(h) % 8 == 0);
`else
    return model_inwin(int'(h), vbl_n);
`endif
  endfunction

  // Video predictor: a fetch is issued on each PIX_CE edge of a slot count in the window.
  initial forever begin
    @(posedge clk);
    edge_n++;
    if (!rst_n) vq.delete();
    else if (pix_ce && model_inwin(int'(h), vbl_n) && (int'(h) % 8 == 0))
      vq.push_back('{edge_n + 2, ref_mem[vid_addr]});
  end

  // Monitor: pops expectations whenever the DUT presents a video strobe or CPU ack.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      vq.delete();
      last_rd = 8'd0;
    end else begin
      bit         exp_stb;
      logic [7:0] exp_d;
      exp_stb = (vq.size() > 0) && (vq[0].due == edge_n);
      exp_d   = exp_stb ? vq[0].data : 8'h00;
      if (vid_stb || exp_stb) begin
        checks++;
        if (!(vid_stb && exp_stb && vid_dout == exp_d)) begin
          errors++;
          $display("FAIL vid_fetch edge %0d: stb=%0b dout=%02h, required stb=%0b dout=%02h",
                   edge_n, vid_stb, vid_dout, exp_stb, exp_d);
        end
      end
      if (exp_stb) void'(vq.pop_front());
      while (vq.size() > 0 && vq[0].due < edge_n) void'(vq.pop_front());
      if (cpu_ack) begin
        checks++;
        if (cq.size() == 0) begin
          errors++;
          $display("FAIL cpu_ack edge %0d: ack=1, required no ack", edge_n);
        end else begin
          cexp_t e;
          e = cq.pop_front();
          if (!e.we && cpu_dout != e.data) begin
            errors++;
            $display("FAIL cpu_read_data: got %02h, required %02h", cpu_dout, e.data);
          end else if (e.we && cpu_dout != last_rd) begin
            errors++;
            $display("FAIL cpu_dout_hold: got %02h, required %02h", cpu_dout, last_rd);
          end
          if (!e.we) last_rd = e.data;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pix_ce) h = (h == H_MOD - 10'd1) ? 10'd0 : h + 10'd1;
    pix_ce   = ~pix_ce;
    vid_addr = 10'($urandom_range(0, 511));
  endtask

  task automatic set_h(input logic [9:0] v);
    h = v;
    pix_ce = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [9:0] addr, input logic [7:0] din,
                            input int hold, input int exp_wait);
    int start, iss, wl;
    bit done;
    cq.push_back('{we, we ? din : ref_mem[addr]});
    cpu_we = we; cpu_addr = addr; cpu_din = din; cpu_req = 1'b1;
    start = edge_n; iss = -1; wl = 0; done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!cpu_waitn) wl++;
      if (iss < 0 && !model_blocked()) begin
        iss = edge_n + 1;
        last_iss_h = int'(h);
      end
      tick();
      if (cpu_ack) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL cpu_timeout: no ack after 3000 cycles, required ack at edge %0d", iss + 2);
      if (cq.size() > 0) void'(cq.pop_back());
      cpu_req = 1'b0;
      tick();
      return;
    end
    chk("ack_latency", edge_n, iss + 2);
    chk("waitn_low_cycles", wl, edge_n - start);
    if (exp_wait > 0) chk("waitn_low_exact", wl, exp_wait);
    if (we) ref_mem[addr] = din;
    tick();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("held_req_waitn", int'(cpu_waitn), 1);
      chk("held_req_no_ack", int'(cpu_ack), 0);
      if (we) chk("held_req_no_we", int'(ram_we), 0);
      tick();
    end
    cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(10'(i));

    // Reset values
    repeat (3) tick();
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_din", int'(ram_din), 0);
    chk("rst_cpu_dout", int'(cpu_dout), 0);
    chk("rst_cpu_ack", int'(cpu_ack), 0);
    chk("rst_vid_dout", int'(vid_dout), 0);
    chk("rst_vid_stb", int'(vid_stb), 0);
    chk("rst_waitn", int'(cpu_waitn), 1);
    rst_n = 1'b1;
    repeat (2) tick();

    // Vblank write then read at the top address: three WAIT cycles each
    vbl_n = 1'b0;
    cpu_access(1'b1, 10'h3FF, 8'h5A, 0, 3);
    cpu_access(1'b0, 10'h3FF, 8'h00, 0, 3);

    // Reset in the middle of a write
    cpu_we = 1'b1; cpu_addr = 10'h2AA; cpu_din = 8'h11; cpu_req = 1'b1;
    tick();
    chk("iss_we_set", int'(ram_we), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", int'(ram_we), 0);
    chk("midrst_ack", int'(cpu_ack), 0);
    chk("midrst_cpu_dout", int'(cpu_dout), 0);
    chk("midrst_ram_addr", int'(ram_addr), 0);
    chk("midrst_waitn_req", int'(cpu_waitn), 0);
    cpu_req = 1'b0;
    #1;
    chk("midrst_waitn_idle", int'(cpu_waitn), 1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_ack || ram_we) cnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_ack || ram_we) cnt++;
    end
    chk("midrst_no_access", cnt, 0);
    cpu_access(1'b0, 10'h2AA, 8'h00, 0, 3);

    // Held request after ACK is served once
    cpu_access(1'b1, 10'h234, 8'hC3, 10, 3);
    cpu_access(1'b0, 10'h234, 8'h00, 10, 3);

    // Request raised on the video slot count inside the window
    vbl_n = 1'b1;
    set_h(10'd104);
    cpu_access(1'b0, 10'h234, 8'h00, 0, 0);

    // Request at H=200 inside the window
    set_h(10'd200);
    cpu_access(1'b0, 10'h3FF, 8'h00, 0, 0);
`ifdef DKONG3_VRAM_SLOT_SHARE_EN
    chk("share_iss_h", last_iss_h, 201);
`else
    chk("noshare_iss_h", last_iss_h, 504);
`endif

    // Window edges and wrap: only the 760 and 0 groups fetch
    vbl_n = 1'b0;
    repeat (6) tick();
    vbl_n = 1'b1;
    set_h(10'd504);
    cnt = 0;
    for (int i = 0; i < 2000 && !(h == 10'd8 && !pix_ce); i++) begin
      @(negedge clk);
      if (vid_stb) cnt++;
      tick();
    end
    chk("wrap_stb_count", cnt, 2);

    // Random traffic
    for (int n = 0; n < 30; n++) begin
      logic       we;
      logic [9:0] a;
      repeat ($urandom_range(0, 5)) begin
        vbl_n = ($urandom_range(0, 9) < 6) ? 1'b0 : 1'b1;
        tick();
      end
      we = 1'($urandom_range(0, 1));
      a  = 10'($urandom_range(512, 1023));
      cpu_access(we, a, 8'($urandom_range(0, 255)), $urandom_range(0, 3), 0);
    end

    repeat (6) tick();
    chk("cpu_queue_drained", cq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
